// File: rtl/laplace_pkg.sv
// laplace_pkg: shared widths, FSM/tap enums and tap offset helper for the Laplace scan controller.
package laplace_pkg;
  localparam int PIX_W = 8;
  localparam int S_W = 9;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_WRITE, S_DONE} state_e;
  typedef enum logic [2:0] {TAP_B, TAP_D, TAP_E, TAP_F, TAP_H} tap_e;
  // Offset of each stencil tap from the top-left corner (base) of its 3x3 window.
  function automatic int unsigned tap_off(tap_e t, int unsigned cols);
    return t == TAP_B ? 32'd1 :
           t == TAP_D ? cols :
           t == TAP_E ? cols + 32'd1 :
           t == TAP_F ? cols + 32'd2 : 32'd2 * cols + 32'd1;
  endfunction
endpackage

// File: rtl/laplace_scan_ctrl_if.sv
// laplace_scan_ctrl_if: frame control, source-RAM read and destination write signals.
interface laplace_scan_ctrl_if #(parameter int ADDR_W = 18);
  import laplace_pkg::*;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0] wr_data;
  logic wr_ready;
  modport master (
    input start, abort, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
  modport slave (
    output start, abort, rd_data, wr_ready,
    input busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/laplace_aproximado_1.sv
// laplace_aproximado_1: combinational approximate 5-point stencil, s = e + (b+d+f+h)/4.
module laplace_aproximado_1 (
  input logic [7:0] b,
  input logic [7:0] d,
  input logic [7:0] e,
  input logic [7:0] f,
  input logic [7:0] h,
  output logic [8:0] s
);
  logic [9:0] sum;
  logic [10:0] acc;
  assign sum = {2'b00, b} + {2'b00, d} + {2'b00, f} + {2'b00, h};
  // 4*e is divisible by 4, so the shift yields e + floor(sum/4) exactly.
  assign acc = {1'b0, e, 2'b00} + {1'b0, sum};
  assign s = 9'(acc >> 2);
endmodule

// File: rtl/laplace_scan_ctrl.sv
// laplace_scan_ctrl: raster sequencer fetching b,d,e,f,h per interior pixel and writing the stencil result.
// Define LAPLACE_SAT_EN to saturate the 9-bit result to 8'hFF instead of truncating.
module laplace_scan_ctrl
  import laplace_pkg::*;
#(
  parameter int ROWS = 512,
  parameter int COLS = 512,
  parameter int ADDR_W = 18
) (
  input logic clk,
  input logic rst_n,
  laplace_scan_ctrl_if.master bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] K_LAST = RW'(ROWS - 3);
  localparam logic [CW-1:0] J_LAST = CW'(COLS - 3);
  state_e st_q;
  tap_e t_q;
  logic [RW-1:0] k_q;
  logic [CW-1:0] j_q;
  logic [ADDR_W-1:0] base_q, base_d, rd_addr_q, wr_addr_q;
  logic busy_q, done_q, rd_en_q, wr_en_q, last;
  logic [4:0][PIX_W-1:0] tap_q;
  logic [S_W-1:0] s;
  // Skipping the two border columns at a row wrap means +3 instead of +1.
  always_comb base_d = base_q + ((j_q == J_LAST) ? ADDR_W'(3) : ADDR_W'(1));
  assign last = (k_q == K_LAST) && (j_q == J_LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= S_IDLE;
      t_q <= TAP_B;
      k_q <= '0;
      j_q <= '0;
      base_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      tap_q <= '0;
    end else if (bus.abort && st_q != S_IDLE) begin
      st_q <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else
      case (st_q)
        S_IDLE:
          if (bus.start && !bus.abort) begin
            st_q <= S_FETCH;
            t_q <= TAP_B;
            k_q <= '0;
            j_q <= '0;
            base_q <= '0;
            wr_addr_q <= '0;
            busy_q <= 1'b1;
            rd_en_q <= 1'b1;
            rd_addr_q <= ADDR_W'(tap_off(TAP_B, COLS));
          end
        S_FETCH: begin
          // Data for the previous tap address returns one cycle after its strobe.
          if (t_q != TAP_B) tap_q[t_q - 3'd1] <= bus.rd_data;
          if (t_q == TAP_H) begin
            st_q <= S_LAST;
            rd_en_q <= 1'b0;
          end else begin
            t_q <= tap_e'(t_q + 3'd1);
            rd_addr_q <= base_q + ADDR_W'(tap_off(tap_e'(t_q + 3'd1), COLS));
          end
        end
        S_LAST: begin
          tap_q[TAP_H] <= bus.rd_data;
          st_q <= S_WRITE;
          wr_en_q <= 1'b1;
        end
        S_WRITE:
          if (bus.wr_ready) begin
            wr_en_q <= 1'b0;
            if (last) begin
              st_q <= S_DONE;
              done_q <= 1'b1;
            end else begin
              st_q <= S_FETCH;
              t_q <= TAP_B;
              wr_addr_q <= wr_addr_q + ADDR_W'(1);
              base_q <= base_d;
              rd_en_q <= 1'b1;
              rd_addr_q <= base_d + ADDR_W'(tap_off(TAP_B, COLS));
              j_q <= (j_q == J_LAST) ? '0 : j_q + 1'b1;
              k_q <= (j_q == J_LAST) ? k_q + 1'b1 : k_q;
            end
          end
        S_DONE: begin
          st_q <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: st_q <= S_IDLE;
      endcase
  laplace_aproximado_1 u_stencil (
    .b(tap_q[TAP_B]),
    .d(tap_q[TAP_D]),
    .e(tap_q[TAP_E]),
    .f(tap_q[TAP_F]),
    .h(tap_q[TAP_H]),
    .s(s)
  );
`ifdef LAPLACE_SAT_EN
  assign bus.wr_data = s[S_W-1] ? '1 : PIX_W'(s);
`else
  assign bus.wr_data = PIX_W'(s);
`endif
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rd_en = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
endmodule
